dp_ram_be_clr: RTL and testbench
================================

Name: dp_ram_be_clr

Overview:
Parametrised successor to the team's simple dual-port synchronous RAM. It has one write port and one read port on a single clock, and adds per-byte write enables, a selectable read-during-write policy and an optional output pipeline register. It also runs a hardware clear sequence after reset that zeroes every location. It is used as the generic buffer and register-file memory in datapaths that need deterministic contents after reset.

Parameters:
RAM_width, 32, data word width in bits; must be a multiple of BYTE_width.
BYTE_width, 8, bits per write-enable lane; lanes = RAM_width/BYTE_width.
RAM_depth, 256, number of words; must satisfy RAM_depth <= 2**address_size.
address_size, 8, width of the address ports.
RDW_MODE, 0, same-address read-during-write policy: 0 = old data, 1 = new data (forwarded).
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset; starts the clear sequence.
write_enable  input  1  write request.
byte_enable  input  RAM_width/BYTE_width  per-lane write mask; bit i covers data_in[i*BYTE_width +: BYTE_width].
write_address  input  address_size  write location.
data_in  input  RAM_width  write data.
read_enable  input  1  read request.
read_address  input  address_size  read location.
data_out  output  RAM_width  read data; holds its last value when no read completes.
read_valid  output  1  one-cycle pulse, aligned with new data_out.
busy  output  1  high while reset or clearing; all requests are ignored while high.

Behaviour:
- Reset values: data_out=0, read_valid=0, busy=1, FSM=CLEAR, clear pointer=0, output pipeline stage cleared.
- Reset is synchronous and active-high. It takes effect only on a rising clk edge where reset=1.
- FSM CLEAR:
  - While reset is held, the pointer stays at 0.
  - Once reset=0, one word is zeroed per cycle at the pointer address, and the pointer increments.
  - After the edge that writes word RAM_depth-1, the FSM moves to RUN and busy falls on that same edge.
  - Exactly RAM_depth cycles elapse between the first reset-low edge and busy=0.
- While busy=1, write_enable and read_enable are ignored: no write occurs and read_valid stays 0.
- Write (RUN state, write_enable=1): on the edge, only lanes with byte_enable[i]=1 are updated. byte_enable=0 performs no write.
- Read (RUN state, read_enable=1 sampled at edge N):
  - OUT_REG=0: data_out and read_valid=1 appear after edge N.
  - OUT_REG=1: data_out and read_valid=1 appear after edge N+1.
  - Back-to-back reads give one result per cycle with no bubbles.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word. Enabled lanes come from data_in; the other lanes come from the old contents.
- Different-address simultaneous read and write: fully independent.
- Out-of-range address (>= RAM_depth):
  - The write is dropped and no other word is disturbed.
  - The read returns 0 with read_valid=1.
- Reset mid-operation:
  - Any in-flight pipelined read is discarded: read_valid=0 and data_out=0.
  - The clear sequence restarts at address 0, including when reset arrives during an active clear.
- Memory contents persist across cycles where neither port is enabled. Reads never modify memory.

Test Plan:
1. Defaults. Hold reset 2 cycles, then release. busy stays 1 for exactly 256 cycles after release, then falls. Read 0x23 -> data_out=0x00000000 with read_valid pulse 1 cycle later.
2. Write 0xAABBCCDD to 0x23 with byte_enable=4'b1111. Next cycle read 0x23 -> data_out=0xAABBCCDD, read_valid high for exactly 1 cycle (OUT_REG=0), 2-cycle latency with OUT_REG=1.
3. With 0x23=0xAABBCCDD, write 0x11223344 with byte_enable=4'b0101. Read 0x23 -> 0xAA22CC44. Write with byte_enable=0 -> contents unchanged.
4. With 0x23=0xAABBCCDD, write 0x55667788 (mask 1111) and read 0x23 in the same cycle:
   - RDW_MODE=0 -> 0xAABBCCDD.
   - RDW_MODE=1 -> 0x55667788.
   - With mask 0011 and RDW_MODE=1 -> 0xAABB7788.
   - A subsequent read in any mode returns the written value.
5. Streaming: fill 0x00..0x0F with value = address. Read 16 consecutive addresses back-to-back -> 16 consecutive read_valid cycles returning 0..15 in order, for both OUT_REG settings.
6. Reset mid-operation:
   - Assert reset 1 cycle while a read is in flight and 0x23 holds data. read_valid stays 0 and busy=1.
   - A write to 0x40 during busy is ignored.
   - After clear, reads of 0x23 and 0x40 return 0.
   - Asserting reset at pointer=100 during a clear restarts the 256-cycle count.

Source files
------------

// File: rtl/dp_ram_be_clr.sv
`timescale 1ns/1ps
// Dual-port (1W/1R) synchronous RAM with byte enables, read-during-write policy and a post-reset zero fill.
// Latency: read data 1 cycle after the request edge, 2 with OUT_REG=1; writes take effect on the request edge.
// Backpressure: none on the ports; requests are ignored while busy (reset or clear sequence running).
//
// Ports:
//   clk, reset             - single clock, synchronous active-high reset (restarts the clear sequence)
//   write_enable/byte_enable/write_address/data_in - write port, one lane per BYTE_width bits
//   read_enable/read_address                      - read port
//   data_out/read_valid    - read result, read_valid pulses for one cycle with each new result
//   busy                   - high from reset until every word has been zeroed
module dp_ram_be_clr #(
    parameter int RAM_width    = 32,
    parameter int BYTE_width   = 8,
    parameter int RAM_depth    = 256,
    parameter int address_size = 8,
    parameter int RDW_MODE     = 0,
    parameter int OUT_REG      = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write_enable,
    input  logic [RAM_width/BYTE_width-1:0]     byte_enable,
    input  logic [address_size-1:0]             write_address,
    input  logic [RAM_width-1:0]                data_in,
    input  logic                                read_enable,
    input  logic [address_size-1:0]             read_address,
    output logic [RAM_width-1:0]                data_out,
    output logic                                read_valid,
    output logic                                busy
);

    localparam int LANES = RAM_width / BYTE_width;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // One extra bit so RAM_depth == 2**address_size is representable.
    localparam logic [address_size:0]   DEPTH_L = (address_size + 1)'(RAM_depth);
    localparam logic [address_size-1:0] LAST_L  = address_size'(RAM_depth - 1);

    logic [RAM_width-1:0]    mem_q [RAM_depth];

    logic [0:0]              state_q, state_d;
    logic [address_size-1:0] clr_ptr_q, clr_ptr_d;

    logic                    run;
    logic                    wr_in_rng, rd_in_rng;
    logic                    wr_fire, rd_fire;
    logic [RAM_width-1:0]    wr_word;
    logic [RAM_width-1:0]    rd_word;
    logic                    fin_vld;
    logic [RAM_width-1:0]    fin_dat;
    logic [RAM_width-1:0]    data_out_q;
    logic                    read_valid_q;

    assign run       = (state_q == ST_RUN);
    assign wr_in_rng = ({1'b0, write_address} < DEPTH_L);
    assign rd_in_rng = ({1'b0, read_address} < DEPTH_L);
    // Out-of-range writes are dropped here so no other word can be disturbed.
    assign wr_fire   = run & write_enable & wr_in_rng;
    assign rd_fire   = run & read_enable;

    // Merged word: enabled lanes from data_in, the rest from the current contents.
    always_comb begin
        wr_word = mem_q[write_address];
        for (int i = 0; i < LANES; i++) begin
            if (byte_enable[i]) begin
                wr_word[i*BYTE_width +: BYTE_width] = data_in[i*BYTE_width +: BYTE_width];
            end
        end
    end

    // Out-of-range reads still complete, returning zero. With RDW_MODE=1 a
    // same-address write is forwarded so the read sees the merged word.
    always_comb begin
        rd_word = '0;
        if (rd_in_rng) begin
            rd_word = mem_q[read_address];
            if ((RDW_MODE != 0) && wr_fire && (write_address == read_address)) begin
                rd_word = wr_word;
            end
        end
    end

    // Clear FSM: one word per cycle; leaves CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_L) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Storage has no reset of its own; the clear sequence provides the zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                mem_q[write_address] <= wr_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : gen_oreg
            logic                 p_vld_q;
            logic [RAM_width-1:0] p_dat_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    p_vld_q <= 1'b0;
                    p_dat_q <= '0;
                end else begin
                    p_vld_q <= rd_fire;
                    p_dat_q <= rd_word;
                end
            end

            assign fin_vld = p_vld_q;
            assign fin_dat = p_dat_q;
        end else begin : gen_noreg
            assign fin_vld = rd_fire;
            assign fin_dat = rd_word;
        end
    endgenerate

    // data_out only moves when a read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= fin_vld;
            if (fin_vld) begin
                data_out_q <= fin_dat;
            end
        end
    end

    assign data_out   = data_out_q;
    assign read_valid = read_valid_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dp_ram_be_clr.sv
`timescale 1ns/1ps
module tb_dp_ram_be_clr;

    typedef struct packed {
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [3:0]  byte_enable;
    logic [7:0]  write_address;
    logic [31:0] data_in;
    logic        read_enable;
    logic [7:0]  read_address;

    // a: RDW_MODE=0, OUT_REG=0   b: RDW_MODE=1, OUT_REG=1
    logic [31:0] dout_a, dout_b;
    logic        rv_a, rv_b;
    logic        busy_a, busy_b;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        run_m = 1'b0;
    logic [31:0] mem_m [256];
    exp_t        q_a[$];
    exp_t        q_b[$];

    dp_ram_be_clr #(.RDW_MODE(0), .OUT_REG(0)) dut_a (
        .clk(clk), .reset(reset), .write_enable(write_enable), .byte_enable(byte_enable),
        .write_address(write_address), .data_in(data_in), .read_enable(read_enable),
        .read_address(read_address), .data_out(dout_a), .read_valid(rv_a), .busy(busy_a)
    );

    dp_ram_be_clr #(.RDW_MODE(1), .OUT_REG(1)) dut_b (
        .clk(clk), .reset(reset), .write_enable(write_enable), .byte_enable(byte_enable),
        .write_address(write_address), .data_in(data_in), .read_enable(read_enable),
        .read_address(read_address), .data_out(dout_b), .read_valid(rv_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for DUT a.
    always @(negedge clk) begin
        exp_t e;
        if (rv_a === 1'b1) begin
            checks++;
            assert (q_a.size() != 0) else begin
                failures++;
                $error("FAIL a_spurious_valid observed=valid expected=no_read cyc=%0d", cyc);
            end
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_data", dout_a, e.dat);
                chk("a_latency", 32'(cyc), 32'(e.due));
            end
        end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
            e = q_a.pop_front();
            checks++;
            assert (1'b0 === rv_a) else begin end
            failures++;
            $error("FAIL a_missing_valid observed=%b expected=1 due=%0d", rv_a, e.due);
        end
    end

    // Scoreboard for DUT b.
    always @(negedge clk) begin
        exp_t e;
        if (rv_b === 1'b1) begin
            checks++;
            assert (q_b.size() != 0) else begin
                failures++;
                $error("FAIL b_spurious_valid observed=valid expected=no_read cyc=%0d", cyc);
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_data", dout_b, e.dat);
                chk("b_latency", 32'(cyc), 32'(e.due));
            end
        end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
            e = q_b.pop_front();
            checks++;
            failures++;
            $error("FAIL b_missing_valid observed=%b expected=1 due=%0d", rv_b, e.due);
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drive one cycle of requests; model and scoreboard only track the RUN state.
    task automatic drive(input logic we, input logic [3:0] be, input logic [7:0] wa,
                         input logic [31:0] di, input logic re, input logic [7:0] ra);
        exp_t        ea, eb;
        logic [31:0] old, nw;
        write_enable  = we;
        byte_enable   = be;
        write_address = wa;
        data_in       = di;
        read_enable   = re;
        read_address  = ra;
        if (run_m) begin
            nw = merge(mem_m[wa], di, be);
            if (re) begin
                old    = mem_m[ra];
                ea.dat = old;
                ea.due = cyc + 1;
                eb.dat = (we && wa == ra) ? nw : old;
                eb.due = cyc + 2;
                q_a.push_back(ea);
                q_b.push_back(eb);
            end
            if (we) mem_m[wa] = nw;
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    endtask

    // Counts edges from reset release until busy falls; n0 covers cycles already spent.
    task automatic wait_clear(input int n0, input string tag);
        int n;
        n = n0;
        while (n < 1000 && busy_a === 1'b1) begin
            idle(1);
            n++;
        end
        chk(tag, 32'(n), 32'd256);
        chk({tag, "_b"}, {31'h0, busy_b}, 32'h0);
        run_m = (busy_a === 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        write_enable = 1'b0; byte_enable = 4'h0; write_address = 8'h0;
        data_in = 32'h0; read_enable = 1'b0; read_address = 8'h0;
        zero_model();
        tick();
        tick();
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_dout_b", dout_b, 32'h0);
        chk("rst_rv_a", {31'h0, rv_a}, 32'h0);
        chk("rst_rv_b", {31'h0, rv_b}, 32'h0);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h1);
        chk("rst_busy_b", {31'h0, busy_b}, 32'h1);
        reset = 1'b0;
        wait_clear(0, "clear_len");

        // Cleared word reads as zero.
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        idle(3);

        // Full write then read.
        drive(1'b1, 4'hF, 8'h23, 32'hAABBCCDD, 1'b0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        idle(3);

        // Partial lanes, then an all-lanes-off write that must change nothing.
        drive(1'b1, 4'b0101, 8'h23, 32'h11223344, 1'b0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        drive(1'b1, 4'b0000, 8'h23, 32'hFFFFFFFF, 1'b0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        idle(3);

        // Read-during-write, full and partial masks, then re-read.
        drive(1'b1, 4'hF, 8'h23, 32'hAABBCCDD, 1'b0, 8'h00);
        drive(1'b1, 4'hF, 8'h23, 32'h55667788, 1'b1, 8'h23);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        drive(1'b1, 4'hF, 8'h23, 32'hAABBCCDD, 1'b0, 8'h00);
        drive(1'b1, 4'b0011, 8'h23, 32'h55667788, 1'b1, 8'h23);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        idle(3);

        // Different-address simultaneous access.
        drive(1'b1, 4'hF, 8'h50, 32'h0BADF00D, 1'b1, 8'h23);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h50);
        idle(3);

        // Streaming fill and back-to-back read-out.
        for (int i = 0; i < 16; i++) drive(1'b1, 4'hF, 8'(i), 32'(i), 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(i));
        idle(4);

        // Reset while a read is in flight in the registered-output instance.
        drive(1'b1, 4'hF, 8'h23, 32'hDEADBEEF, 1'b0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        q_b.delete();
        run_m = 1'b0;
        zero_model();
        reset = 1'b1;
        drive(1'b1, 4'hF, 8'h40, 32'h12345678, 1'b0, 8'h00);
        chk("midrst_rv_a", {31'h0, rv_a}, 32'h0);
        chk("midrst_rv_b", {31'h0, rv_b}, 32'h0);
        chk("midrst_dout_a", dout_a, 32'h0);
        chk("midrst_dout_b", dout_b, 32'h0);
        chk("midrst_busy", {31'h0, busy_a}, 32'h1);
        reset = 1'b0;
        drive(1'b1, 4'hF, 8'h40, 32'h12345678, 1'b1, 8'h40);
        wait_clear(1, "reclear_len");
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h23);
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h40);
        idle(3);

        // Reset arriving partway through a clear restarts the count.
        drive(1'b1, 4'hF, 8'h07, 32'hCAFEF00D, 1'b0, 8'h00);
        run_m = 1'b0;
        zero_model();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(100);
        reset = 1'b1;
        idle(1);
        chk("clr_restart_busy", {31'h0, busy_a}, 32'h1);
        reset = 1'b0;
        wait_clear(0, "restart_len");
        drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h07);
        idle(4);

        chk("drain_a", 32'(q_a.size()), 32'h0);
        chk("drain_b", 32'(q_b.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
